// File: rtl/aes_pkg.sv
// Shared types for the aes_core request scheduler.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
      // Explicit wrap so non-power-of-two NREQ never walks past the last requester.
      cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/aes_core_arb.sv
// Shares one aes_core among NREQ requesters: round-robin accept, load pulse,
// wait for done (with watchdog abort), then return the cyphertext on a valid/ready channel.
module aes_core_arb
  import aes_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_pt,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [127:0]      rsp_ct,
  output logic              rsp_err,
  output logic              core_load,
  output logic [127:0]      core_key,
  output logic [127:0]      core_pt,
  input  logic              core_done,
  input  logic [127:0]      core_ct,
  output logic              busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int LC_W  = $clog2(LOAD_CYC + 1);
  localparam int WD_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREQ - 1);
  localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(LOAD_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  block_t           key_q, key_d;
  block_t           pt_q, pt_d;
  block_t           ct_q, ct_d;
  logic             err_q, err_d;
  logic [LC_W-1:0]  load_cnt_q, load_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             accept;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Any valid request yields a grant, so the handshake is simply "IDLE and something valid".
  assign accept = (state_q == IDLE) && (|req_valid);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    if (load_cnt_q == LOAD_LAST) state_d = WAIT;
      WAIT:    if (core_done || (wd_cnt_q == WD_LAST)) state_d = RESP;
      RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    owner_d    = owner_q;
    key_d      = key_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    err_d      = err_q;
    load_cnt_d = load_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d    = gnt_idx;
          key_d      = req_key[128*gnt_idx +: 128];
          pt_d       = req_pt[128*gnt_idx +: 128];
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        load_cnt_d = load_cnt_q + 1'b1;
        wd_cnt_d   = '0;
      end
      WAIT: begin
        // Done is checked first so a coincident timeout still returns real data.
        if (core_done) begin
          ct_d  = core_ct;
          err_d = 1'b0;
        end else if (wd_cnt_q == WD_LAST) begin
          ct_d  = '0;
          err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) rr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q       <= '0;
      owner_q    <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
      err_q      <= 1'b0;
      load_cnt_q <= '0;
      wd_cnt_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      err_q      <= err_d;
      load_cnt_q <= load_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    core_load = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    if (reset) req_ready = gnt;
      LOAD:    core_load = 1'b1;
      RESP:    rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign core_key = key_q;
  assign core_pt  = pt_q;
  assign rsp_ct   = ct_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_aes_core_arb.sv
// Randomized bench for aes_core_arb with a behavioural core model and round-robin reference.
module tb_aes_core_arb;
  import aes_pkg::*;

  localparam int NREQ     = 4;
  localparam int LOAD_CYC = 2;
  localparam int TIMEOUT  = 64;
  localparam int BOUND    = 300;

  localparam block_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [NREQ-1:0] ALL = '1;
  localparam logic [NREQ-1:0] ONE = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*128-1:0] req_key = '0;
  logic [NREQ*128-1:0] req_pt = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [127:0]      rsp_ct;
  logic              rsp_err;
  logic              core_load;
  logic [127:0]      core_key;
  logic [127:0]      core_pt;
  logic              core_done = 1'b0;
  logic [127:0]      core_ct = '0;
  logic              busy;

  aes_core_arb #(.NREQ(NREQ), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_pt    (req_pt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ct    (rsp_ct),
    .rsp_err   (rsp_err),
    .core_load (core_load),
    .core_key  (core_key),
    .core_pt   (core_pt),
    .core_done (core_done),
    .core_ct   (core_ct),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_rr = 0;
  block_t keys [NREQ];
  block_t pts  [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic block_t ref_ct(block_t k, block_t p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'hc3a5_5a3c_0ff0_f00f_1234_5678_9abc_def0;
  endfunction

  function automatic int ref_grant(logic [NREQ-1:0] v, int rr);
    for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2idx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic block_t rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: starts on the falling edge of load, raises done core_lat cycles later.
  int     core_lat = 2;
  bit     core_hang = 1'b0;
  bit     loading = 1'b0;
  bit     active = 1'b0;
  int     cd = 0;
  block_t ck, cp;

  always @(posedge clk) begin
    #1;
    if (core_load) begin
      core_done = 1'b0;
      loading   = 1'b1;
      active    = 1'b0;
      ck        = core_key;
      cp        = core_pt;
    end else if (loading) begin
      loading = 1'b0;
      if (!core_hang) begin
        active = 1'b1;
        cd     = core_lat;
      end
    end
    if (active) begin
      if (cd == 0) begin
        core_done = 1'b1;
        core_ct   = ref_ct(ck, cp);
        active    = 1'b0;
      end else begin
        cd--;
      end
    end
  end

  // Transaction logs sampled on the falling edge.
  int     acc_idx_q[$];
  int     acc_cyc_q[$];
  int     rsp_idx_q[$];
  block_t rsp_ct_q[$];
  logic   rsp_err_q[$];
  int     rsp_cyc_q[$];
  int     load_len_q[$];
  int     wait_cyc = 0;
  int     load_run = 0;
  logic   prev_load = 1'b0;
  logic [NREQ-1:0] prev_rsp = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (|(req_valid & req_ready)) begin
        acc_idx_q.push_back(oh2idx(req_valid & req_ready));
        acc_cyc_q.push_back(cyc + 1);
      end
      if (|(rsp_valid & rsp_ready)) begin
        rsp_idx_q.push_back(oh2idx(rsp_valid & rsp_ready));
        rsp_ct_q.push_back(rsp_ct);
        rsp_err_q.push_back(rsp_err);
        $display("rsp req=%0d err=%0b ct=%h cyc=%0d", oh2idx(rsp_valid & rsp_ready), rsp_err, rsp_ct, cyc);
      end
      if (rsp_valid != 0 && prev_rsp == 0) rsp_cyc_q.push_back(cyc);
      if (prev_load && !core_load && busy) wait_cyc = cyc;
    end
    if (core_load) load_run++;
    else if (load_run > 0) begin
      load_len_q.push_back(load_run);
      load_run = 0;
    end
    prev_load = core_load;
    prev_rsp  = rsp_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_idx_q.delete(); acc_cyc_q.delete();
    rsp_idx_q.delete(); rsp_ct_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete();
    load_len_q.delete();
  endtask

  task automatic set_req_data();
    for (int i = 0; i < NREQ; i++) begin
      keys[i] = rnd_block();
      pts[i]  = rnd_block();
      req_key[128*i +: 128] = keys[i];
      req_pt[128*i +: 128]  = pts[i];
    end
  endtask

  task automatic wait_acc(input int n, output bit ok);
    int c = 0;
    while (acc_idx_q.size() < n && c < BOUND) begin tick(1); c++; end
    ok = (acc_idx_q.size() >= n);
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int c = 0;
    while (rsp_idx_q.size() < n && c < BOUND) begin tick(1); c++; end
    ok = (rsp_idx_q.size() >= n);
  endtask

  task automatic wait_rsp_valid(output bit ok);
    int c = 0;
    while (rsp_valid == 0 && c < BOUND) begin tick(1); c++; end
    ok = (rsp_valid != 0);
  endtask

  task automatic wait_idle(output bit ok);
    int c = 0;
    while (busy && c < BOUND) begin tick(1); c++; end
    ok = !busy;
  endtask

  task automatic run_job(input int idx, input block_t k, input block_t p, input int lat, output bit ok);
    bit ok1, ok2, ok3;
    int na, nr;
    core_lat  = lat;
    core_hang = 1'b0;
    req_key[128*idx +: 128] = k;
    req_pt[128*idx +: 128]  = p;
    na = acc_idx_q.size();
    nr = rsp_idx_q.size();
    rsp_ready = ALL;
    req_valid = ONE << idx;
    wait_acc(na + 1, ok1);
    req_valid = '0;
    wait_rsp(nr + 1, ok2);
    wait_idle(ok3);
    ok = ok1 & ok2 & ok3;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    model_rr = 0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    rsp_ready = '0;
    reset = 1'b0;
    tick(3);
    samp();
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (core_load !== 1'b0) begin failures++; $display("FAIL reset_core_load got=%b exp=0", core_load); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (core_key !== '0) begin failures++; $display("FAIL reset_core_key got=%h exp=0", core_key); end
    checks++; if (core_pt !== '0) begin failures++; $display("FAIL reset_core_pt got=%h exp=0", core_pt); end
    checks++; if (rsp_ct !== '0) begin failures++; $display("FAIL reset_rsp_ct got=%h exp=0", rsp_ct); end
    tick(1);
    reset = 1'b1;
    model_rr = 0;
    tick(1);
  endtask

  task automatic test_single();
    bit ok;
    int lat = 3;
    clear_logs();
    core_lat = lat;
    core_hang = 1'b0;
    req_key = '0;
    req_pt = '0;
    req_key[127:0] = FIPS_KEY;
    req_pt[127:0]  = FIPS_PT;
    rsp_ready = '0;
    req_valid = 4'b0001;
    wait_acc(1, ok);
    req_valid = '0;
    wait_rsp_valid(ok);
    samp();
    checks++; if (!ok) begin failures++; $display("FAIL single_rsp_timeout got=no_rsp exp=rsp"); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_ct !== FIPS_CT) begin failures++; $display("FAIL single_rsp_ct got=%h exp=%h", rsp_ct, FIPS_CT); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (core_key !== FIPS_KEY || core_pt !== FIPS_PT) begin failures++; $display("FAIL single_core_payload got=%h/%h exp=%h/%h", core_key, core_pt, FIPS_KEY, FIPS_PT); end
    checks++;
    if (load_len_q.size() != 1 || load_len_q[0] != LOAD_CYC) begin
      failures++; $display("FAIL single_load_len got=%0d exp=%0d", (load_len_q.size() > 0) ? load_len_q[0] : -1, LOAD_CYC);
    end
    checks++;
    if (acc_cyc_q.size() != 1 || rsp_cyc_q.size() != 1 || rsp_cyc_q[0] - acc_cyc_q[0] != LOAD_CYC + lat + 1) begin
      failures++; $display("FAIL single_latency got=%0d exp=%0d",
        (acc_cyc_q.size() > 0 && rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_cyc_q[0] : -1, LOAD_CYC + lat + 1);
    end
    tick(1);
    rsp_ready = ALL;
    wait_rsp(1, ok);
    wait_idle(ok);
    checks++; if (!ok || rsp_idx_q.size() != 1 || rsp_idx_q[0] != 0) begin failures++; $display("FAIL single_complete got=%0d exp=1", rsp_idx_q.size()); end
    model_rr = 1;
  endtask

  task automatic test_round_robin();
    bit ok1, ok2, ok3;
    int exp;
    do_reset();
    clear_logs();
    set_req_data();
    core_lat = $urandom_range(0, 5);
    core_hang = 1'b0;
    rsp_ready = ALL;
    req_valid = ALL;
    wait_acc(5, ok1);
    req_valid = '0;
    wait_rsp(5, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 & ok2 & ok3)) begin failures++; $display("FAIL rr_timeout got=acc%0d/rsp%0d exp=5/5", acc_idx_q.size(), rsp_idx_q.size()); end
    for (int j = 0; j < 5 && j < acc_idx_q.size() && j < rsp_idx_q.size(); j++) begin
      exp = ref_grant(ALL, model_rr);
      checks++; if (acc_idx_q[j] != exp) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", j, acc_idx_q[j], exp); end
      checks++; if (rsp_idx_q[j] != exp) begin failures++; $display("FAIL rr_rsp_owner%0d got=%0d exp=%0d", j, rsp_idx_q[j], exp); end
      checks++;
      if (rsp_ct_q[j] !== ref_ct(keys[exp], pts[exp]) || rsp_err_q[j] !== 1'b0) begin
        failures++; $display("FAIL rr_ct%0d got=%h err=%b exp=%h", j, rsp_ct_q[j], rsp_err_q[j], ref_ct(keys[exp], pts[exp]));
      end
      model_rr = (exp + 1) % NREQ;
    end
  endtask

  task automatic test_timeout();
    bit ok, ok1, ok2;
    int a, exp;
    clear_logs();
    set_req_data();
    a = $urandom_range(0, NREQ - 1);
    core_hang = 1'b1;
    rsp_ready = '0;
    req_valid = ONE << a;
    wait_acc(1, ok);
    req_valid = '0;
    wait_rsp_valid(ok);
    samp();
    checks++; if (!ok) begin failures++; $display("FAIL timeout_no_rsp got=none exp=rsp"); end
    checks++; if (rsp_valid !== (ONE << a)) begin failures++; $display("FAIL timeout_rsp_valid got=%b exp=%b", rsp_valid, ONE << a); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL timeout_rsp_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_ct !== '0) begin failures++; $display("FAIL timeout_rsp_ct got=%h exp=0", rsp_ct); end
    checks++;
    if (rsp_cyc_q.size() != 1 || rsp_cyc_q[0] - wait_cyc != TIMEOUT) begin
      failures++; $display("FAIL timeout_delay got=%0d exp=%0d", (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - wait_cyc : -1, TIMEOUT);
    end
    tick(1);
    rsp_ready = ALL;
    wait_rsp(1, ok);
    wait_idle(ok);
    model_rr = (a + 1) % NREQ;
    core_hang = 1'b0;
    core_lat = $urandom_range(0, 4);
    req_valid = ALL;
    wait_acc(2, ok1);
    req_valid = '0;
    wait_rsp(2, ok2);
    wait_idle(ok);
    exp = ref_grant(ALL, model_rr);
    checks++; if (!(ok1 & ok2 & ok)) begin failures++; $display("FAIL timeout_next_job got=acc%0d/rsp%0d exp=2/2", acc_idx_q.size(), rsp_idx_q.size()); end
    if (acc_idx_q.size() >= 2 && rsp_idx_q.size() >= 2) begin
      checks++; if (acc_idx_q[1] != exp) begin failures++; $display("FAIL timeout_next_grant got=%0d exp=%0d", acc_idx_q[1], exp); end
      checks++;
      if (rsp_err_q[1] !== 1'b0 || rsp_ct_q[1] !== ref_ct(keys[exp], pts[exp])) begin
        failures++; $display("FAIL timeout_next_ct got=%h err=%b exp=%h", rsp_ct_q[1], rsp_err_q[1], ref_ct(keys[exp], pts[exp]));
      end
    end
    model_rr = (exp + 1) % NREQ;
  endtask

  task automatic test_backpressure();
    bit ok;
    int b;
    block_t exp_ct;
    logic [NREQ-1:0] exp_v;
    clear_logs();
    set_req_data();
    b = $urandom_range(0, NREQ - 1);
    exp_v = ONE << b;
    exp_ct = ref_ct(keys[b], pts[b]);
    core_lat = $urandom_range(0, 6);
    rsp_ready = '0;
    req_valid = exp_v;
    wait_acc(1, ok);
    req_valid = '0;
    wait_rsp_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_no_rsp got=none exp=rsp"); end
    for (int i = 0; i < 20; i++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom) & ~exp_v;
      samp();
      checks++;
      if ({rsp_valid, rsp_ct, rsp_err, req_ready} !== {exp_v, exp_ct, 1'b0, {NREQ{1'b0}}}) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b ct=%h err=%b rdy=%b exp=v%b ct=%h err=0 rdy=0", i, rsp_valid, rsp_ct, rsp_err, req_ready, exp_v, exp_ct);
      end
      tick(1);
    end
    req_valid = '0;
    rsp_ready = ALL;
    wait_rsp(1, ok);
    wait_idle(ok);
    checks++; if (acc_idx_q.size() != 1 || rsp_idx_q.size() != 1 || rsp_idx_q[0] != b) begin failures++; $display("FAIL bp_complete got=acc%0d/rsp%0d exp=1/1", acc_idx_q.size(), rsp_idx_q.size()); end
    model_rr = (b + 1) % NREQ;
  endtask

  task automatic test_reset_mid();
    bit ok, ok1, ok2;
    int c = 0, seen = 0;
    clear_logs();
    set_req_data();
    core_lat = 20;
    rsp_ready = ALL;
    req_valid = ONE << 2;
    wait_acc(1, ok);
    req_valid = '0;
    while (!(busy && !core_load) && c < BOUND) begin tick(1); c++; end
    tick(3);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    samp();
    checks++;
    if ({req_ready, rsp_valid, core_load, busy, rsp_err} !== '0 || core_key !== '0 || core_pt !== '0 || rsp_ct !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=rdy%b v%b ld%b busy%b err%b key%h pt%h ct%h exp=all0", req_ready, rsp_valid, core_load, busy, rsp_err, core_key, core_pt, rsp_ct);
    end
    model_rr = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rsp_valid != 0 || busy) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_ghost got=%0d exp=0", seen); end
    clear_logs();
    set_req_data();
    core_lat = $urandom_range(0, 5);
    req_valid = ALL;
    wait_acc(1, ok1);
    req_valid = '0;
    wait_rsp(1, ok2);
    wait_idle(ok);
    checks++; if (!(ok1 & ok2 & ok)) begin failures++; $display("FAIL midreset_newjob got=acc%0d/rsp%0d exp=1/1", acc_idx_q.size(), rsp_idx_q.size()); end
    if (acc_idx_q.size() >= 1 && rsp_idx_q.size() >= 1) begin
      checks++; if (acc_idx_q[0] != ref_grant(ALL, model_rr)) begin failures++; $display("FAIL midreset_grant got=%0d exp=%0d", acc_idx_q[0], ref_grant(ALL, model_rr)); end
      checks++;
      if (rsp_ct_q[0] !== ref_ct(keys[0], pts[0]) || rsp_err_q[0] !== 1'b0) begin
        failures++; $display("FAIL midreset_ct got=%h err=%b exp=%h", rsp_ct_q[0], rsp_err_q[0], ref_ct(keys[0], pts[0]));
      end
    end
    model_rr = 1;
  endtask

  task automatic test_done_timeout_edge();
    bit ok;
    int d;
    block_t k, p;
    clear_logs();
    d = $urandom_range(0, NREQ - 1);
    k = rnd_block();
    p = rnd_block();
    run_job(d, k, p, TIMEOUT - 1, ok);
    checks++; if (!ok || rsp_idx_q.size() != 1) begin failures++; $display("FAIL coincide_job got=rsp%0d exp=1", rsp_idx_q.size()); end
    else begin
      checks++;
      if (rsp_err_q[0] !== 1'b0 || rsp_ct_q[0] !== ref_ct(k, p)) begin
        failures++; $display("FAIL coincide_done_wins got=%h err=%b exp=%h err=0", rsp_ct_q[0], rsp_err_q[0], ref_ct(k, p));
      end
    end
    run_job(d, k, p, TIMEOUT, ok);
    checks++; if (!ok || rsp_idx_q.size() != 2) begin failures++; $display("FAIL late_done_job got=rsp%0d exp=2", rsp_idx_q.size()); end
    else begin
      checks++;
      if (rsp_err_q[1] !== 1'b1 || rsp_ct_q[1] !== '0) begin
        failures++; $display("FAIL late_done_abort got=%h err=%b exp=0 err=1", rsp_ct_q[1], rsp_err_q[1]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=hung exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_done_timeout_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
